// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency main memory between the I-cache and
// the D-cache. One cache at a time owns the request port; every read is tagged
// with its owner so returned words route back to the issuing cache, even after
// ownership has moved on.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   i_MemRead, i_mem_addr    I-cache read request
//   d_MemRead, d_MemWrite,
//   d_mem_addr,
//   d_mem_write_data         D-cache read/write request
//   i_grant, d_grant         registered ownership flags
//   i_MemDataValid,
//   d_MemDataValid,
//   mem_read_data_out        routed read return (shared data bus)
//   mem_enable, mem_wr,
//   mem_addr, mem_data_in    memory request port (combinational from owner)
//   mem_data_valid,
//   mem_data_out             memory read return
//   proto_err                sticky protocol-error flag
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_MemRead,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic              d_MemRead,
  input  logic              d_MemWrite,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_write_data,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_MemDataValid,
  output logic              d_MemDataValid,
  output logic [DATA_W-1:0] mem_read_data_out,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              proto_err
);

  localparam int unsigned BLANK_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } state_e;

  typedef struct packed {
    logic valid;
    logic owner_d;
  } tag_t;

  state_e             state_q, state_d;
  logic               last_d_q, last_d_d;
  tag_t [MEM_LAT-1:0] tag_q, tag_d;
  tag_t               tag_in;
  tag_t               tail;
  logic [BLANK_W-1:0] blank_q, blank_d;
  logic               perr_q, perr_d;
  logic               i_req, d_req;
  logic               issue_rd, issue_own_d;

  assign i_req = i_MemRead;
  assign d_req = d_MemRead | d_MemWrite;

  // Ownership FSM: re-arbitrate whenever the current owner is not requesting
  // (this also recovers from the unused state encoding).
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    if (!((state_q == OWN_I && i_req) || (state_q == OWN_D && d_req))) begin
      if (d_req && !i_req)      state_d = OWN_D;
      else if (i_req && !d_req) state_d = OWN_I;
      else if (i_req && d_req)  state_d = last_d_q ? OWN_I : OWN_D;
      else                      state_d = IDLE;
      if (state_d == OWN_D)      last_d_d = 1'b1;
      else if (state_d == OWN_I) last_d_d = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  // Memory request port: the owner's access goes out in the same cycle
  always_comb begin
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    issue_rd    = 1'b0;
    issue_own_d = 1'b0;
    if (state_q == OWN_I && i_req) begin
      mem_enable = 1'b1;
      mem_addr   = i_mem_addr;
      issue_rd   = 1'b1;
    end else if (state_q == OWN_D && d_req) begin
      mem_enable  = 1'b1;
      mem_addr    = d_mem_addr;
      mem_wr      = d_MemWrite;
      mem_data_in = d_MemWrite ? d_mem_write_data : '0;
      issue_rd    = !d_MemWrite;
      issue_own_d = 1'b1;
    end
  end

  // Tag pipeline: writes insert an invalid entry so the depth stays aligned
  assign tag_in.valid   = issue_rd;
  assign tag_in.owner_d = issue_own_d;

  if (MEM_LAT > 1) begin : g_shift
    assign tag_d = {tag_q[MEM_LAT-2:0], tag_in};
  end else begin : g_single
    assign tag_d = tag_in;
  end

  assign tail = tag_q[MEM_LAT-1];

  // Blank counter and sticky error detection
  always_comb begin
    blank_d = (blank_q != '0) ? blank_q - BLANK_W'(1) : blank_q;
    perr_d  = perr_q
            | (state_q == OWN_D && d_MemRead && d_MemWrite)
            | (mem_data_valid && !tail.valid && blank_q == '0)
            | (tail.valid && !mem_data_valid);
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q   <= '0;
      blank_q <= BLANK_W'(MEM_LAT);
      perr_q  <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      blank_q <= blank_d;
      perr_q  <= perr_d;
    end
  end

  assign i_grant           = (state_q == OWN_I);
  assign d_grant           = (state_q == OWN_D);
  assign i_MemDataValid    = mem_data_valid & tail.valid & !tail.owner_d;
  assign d_MemDataValid    = mem_data_valid & tail.valid & tail.owner_d;
  assign mem_read_data_out = mem_data_out;
  assign proto_err         = perr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic. A memory model
// answers the DUT's actual reads; a reference model predicts ownership, issued
// accesses and returns, and a monitor compares routed returns from a queue.
module tb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned L  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_MemRead, d_MemRead, d_MemWrite;
  logic [AW-1:0] i_mem_addr, d_mem_addr, mem_addr;
  logic [DW-1:0] d_mem_write_data, mem_read_data_out, mem_data_in, mem_data_out;
  logic          i_grant, d_grant, i_MemDataValid, d_MemDataValid;
  logic          mem_enable, mem_wr, mem_data_valid, proto_err;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .i_MemRead(i_MemRead), .i_mem_addr(i_mem_addr),
    .d_MemRead(d_MemRead), .d_MemWrite(d_MemWrite),
    .d_mem_addr(d_mem_addr), .d_mem_write_data(d_mem_write_data),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_MemDataValid(i_MemDataValid), .d_MemDataValid(d_MemDataValid),
    .mem_read_data_out(mem_read_data_out),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out),
    .proto_err(proto_err)
  );

  typedef struct {
    int          who;   // 1 = I, 2 = D
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          who_at[int];
  logic [15:0] mem_ret[int];

  int errors = 0, checks = 0, cyc = 0;
  bit started = 0;
  int m_own = 0, m_last = 1, since_rst = 1, m_seq = 0, mem_seq = 0;
  bit m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Predicted request-port behaviour for the current cycle
  task automatic model_check();
    bit          iss = 0, wr = 0;
    logic [15:0] a = 16'h0, wd = 16'h0;
    if (m_own == 1 && i_MemRead) begin
      iss = 1; a = i_mem_addr;
    end else if (m_own == 2 && (d_MemRead || d_MemWrite)) begin
      iss = 1; wr = d_MemWrite; a = d_mem_addr;
      wd = d_MemWrite ? d_mem_write_data : 16'h0;
    end
    chk("i_grant", 32'(i_grant), 32'(m_own == 1));
    chk("d_grant", 32'(d_grant), 32'(m_own == 2));
    chk("mem_enable", 32'(mem_enable), 32'(iss));
    chk("mem_wr", 32'(mem_wr), 32'(wr));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    if (!(iss && !wr && m_own == 2)) chk("mem_data_in", 32'(mem_data_in), 32'(wd));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    if (iss && !wr) begin
      m_seq++;
      exp_q.push_back('{who: m_own, data: 16'(m_seq), due: cyc + int'(L)});
      who_at[cyc + int'(L)] = m_own;
    end
  endtask

  // Memory: answers whatever the DUT really issues, MEM_LAT cycles later
  task automatic mem_observe();
    if (mem_enable && !mem_wr) begin
      mem_seq++;
      mem_ret[cyc + int'(L)] = 16'(mem_seq);
    end
  endtask

  // Reference state update at the rising edge
  task automatic model_advance();
    bit ir = i_MemRead;
    bit dr = d_MemRead || d_MemWrite;
    if (!rst) begin
      m_own = 0; m_last = 1; m_perr = 0; since_rst = 1;
      exp_q.delete(); who_at.delete();
    end else begin
      if (m_own == 2 && d_MemRead && d_MemWrite) m_perr = 1;
      if (mem_data_valid && !who_at.exists(cyc) && since_rst > int'(L)) m_perr = 1;
      if (!(m_own == 1 && ir) && !(m_own == 2 && dr)) begin
        if (dr && !ir)      m_own = 2;
        else if (ir && !dr) m_own = 1;
        else if (ir && dr)  m_own = (m_last == 1) ? 2 : 1;
        else                m_own = 0;
        if (m_own != 0) m_last = m_own;
      end
      since_rst++;
    end
    if (who_at.exists(cyc)) who_at.delete(cyc);
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    mem_observe();
    @(posedge clk);
    model_advance();
    #1;
    if (mem_ret.exists(cyc)) begin
      mem_data_valid = 1'b1;
      mem_data_out   = mem_ret[cyc];
      mem_ret.delete(cyc);
    end else begin
      mem_data_valid = 1'b0;
      mem_data_out   = 16'h0;
    end
  endtask

  task automatic idle_inputs();
    i_MemRead = 0; d_MemRead = 0; d_MemWrite = 0;
    i_mem_addr = 0; d_mem_addr = 0; d_mem_write_data = 0;
  endtask

  // Return monitor
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        chk("ret_valid", 32'({i_MemDataValid, d_MemDataValid}), (mon_e.who == 1) ? 32'd2 : 32'd1);
        chk("ret_data", 32'(mem_read_data_out), 32'(mon_e.data));
      end else begin
        chk("no_ret", 32'({i_MemDataValid, d_MemDataValid}), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    mem_data_valid = 1'b0;
    mem_data_out   = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    started = 1;

    // Reset state
    step();
    rst = 1'b1;
    repeat (2) step();

    // I fill: 8 reads, addresses 0x0004..0x000B, data 1..8
    i_MemRead = 1; i_mem_addr = 16'h0004;
    step();
    for (int k = 0; k < 8; k++) begin
      i_mem_addr = 16'(4 + k);
      step();
    end
    idle_inputs();
    repeat (L + 2) step();

    // Tie: D first, handoff to I, second tie goes to D
    i_MemRead = 1; i_mem_addr = 16'h0100; d_MemRead = 1; d_mem_addr = 16'h0200;
    repeat (3) step();
    d_MemRead = 0;
    step();
    repeat (2) step();
    i_MemRead = 0;
    step();
    i_MemRead = 1; d_MemRead = 1;
    step();
    idle_inputs();
    repeat (L + 2) step();

    // Single write
    d_MemWrite = 1; d_mem_addr = 16'h0010; d_mem_write_data = 16'hBEEF;
    repeat (2) step();
    idle_inputs();
    repeat (L + 2) step();

    // Overlap: D reads drain while I issues
    d_MemRead = 1; d_mem_addr = 16'h0400;
    step();
    i_MemRead = 1; i_mem_addr = 16'h0300;
    step();
    d_mem_addr = 16'h0401;
    step();
    d_MemRead = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      i_mem_addr = 16'(16'h0300 + k);
      step();
    end
    idle_inputs();
    repeat (L + 2) step();

    // Spurious return after the blank window
    mem_data_valid = 1'b1; mem_data_out = 16'h5555;
    step();
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (L + 2) step();

    // Reset mid-fill: in-flight words dropped silently
    i_MemRead = 1; i_mem_addr = 16'h0500;
    step();
    for (int k = 0; k < 3; k++) begin
      i_mem_addr = 16'(16'h0500 + k);
      step();
    end
    i_MemRead = 0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (L + 2) step();
    i_MemRead = 1; i_mem_addr = 16'h0600;
    repeat (3) step();
    idle_inputs();
    repeat (L + 2) step();

    // D read and write together while owner
    d_MemRead = 1; d_MemWrite = 1; d_mem_addr = 16'h0700; d_mem_write_data = 16'h1234;
    repeat (2) step();
    idle_inputs();
    repeat (3) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (L + 2) step();

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      int op;
      i_MemRead  = (($urandom % 4) != 0);
      i_mem_addr = 16'($urandom);
      op         = int'($urandom % 3);
      d_MemRead  = (op == 1);
      d_MemWrite = (op == 2);
      d_mem_addr = 16'($urandom);
      d_mem_write_data = 16'($urandom);
      rst = (($urandom % 100) != 0);
      step();
    end
    idle_inputs();
    rst = 1'b1;
    repeat (L + 3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multi-cycle main memory between the I-cache and the D-cache. Each cache's miss/write interface (MemRead, MemWrite, mem_addr, MemDataValid, mem_read_data) connects here instead of to memory. The arbiter grants one cache ownership of the memory request port at a time and tags every issued read. It routes each returned word back to the cache that issued it, so one owner's reads can still be draining while the other owner issues.

## Interface
- ADDR_W, 16, memory address width
- DATA_W, 16, memory data width
- MEM_LAT, 4, fixed cycles from read issue (mem_enable & !mem_wr) to mem_data_valid for that word; ≥1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets all state)
- i_MemRead  in  1  I-cache read request; I-cache never writes
- i_mem_addr  in  ADDR_W  I-cache request address
- d_MemRead  in  1  D-cache read request
- d_MemWrite  in  1  D-cache write request
- d_mem_addr  in  ADDR_W  D-cache request address
- d_mem_write_data  in  DATA_W  D-cache write data
- i_grant, d_grant  out  1  registered ownership flags; at most one high
- i_MemDataValid, d_MemDataValid  out  1  returned word belongs to this cache
- mem_read_data_out  out  DATA_W  returned word; shared by both caches, qualified by the valids
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  access is a write
- mem_addr  out  ADDR_W  access address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_valid  in  1  memory returning a read word this cycle
- mem_data_out  in  DATA_W  returned word
- proto_err  out  1  sticky protocol-error flag

## Operation
- FSM states: IDLE, OWN_I, OWN_D. i_grant = (state==OWN_I); d_grant = (state==OWN_D).
- Request definitions:
  - i_req = i_MemRead
  - d_req = d_MemRead | d_MemWrite
- Decision point: state IDLE, or the current owner's req low. At a decision point the next state is:
  - d_req only → OWN_D
  - i_req only → OWN_I
  - both → the requester ≠ last_owner
  - neither → IDLE
- last_owner updates on every entry to OWN_x. Reset value is I, so D wins the first tie.
- While in OWN_x with x's req high, one access is issued that cycle (combinational from state and inputs):
  - mem_enable=1
  - mem_addr = x's addr
  - mem_wr = d_MemWrite (owner D) or 0 (owner I)
  - mem_data_in = d_mem_write_data (otherwise 0)
- When no access is issued, mem_enable, mem_wr, mem_addr and mem_data_in are all 0.
- D-cache write: a single memory cycle with no data return. The owner drops its req once its accesses are done, and a write-through cache may hold ownership across several writes.
- d_MemRead & d_MemWrite both high while owner is D: the arbiter issues the write and sets proto_err.
- Tag pipeline: MEM_LAT-deep shift register of {valid, owner}. It shifts every cycle. The entry is valid only when a read is issued that cycle (writes insert invalid).
- Return routing:
  - x_MemDataValid = mem_data_valid & tail.valid & tail.owner==x
  - mem_read_data_out = mem_data_out
- mem_data_valid with an invalid tail: the word is dropped and proto_err is set.
- A valid tail without mem_data_valid sets proto_err.
- Post-reset blank: a counter loads MEM_LAT on reset. While it is nonzero, untagged returns are dropped silently without setting proto_err.
- proto_err clears only on reset.

## Timing
- Reset values: state IDLE; last_owner=I; tag pipe all invalid; proto_err=0; blank counter=MEM_LAT. All outputs are 0 (valids are 0 because the tag pipe is empty).
- Grant latency: req rises in cycle t while IDLE → x_grant=1 and first issue in t+1.
- Handoff: owner's req low in cycle t with the other requester pending → the other grant is high in t+1, with no idle gap. The old grant drops in t+1.
- Read return: issued in cycle t → x_MemDataValid in t+MEM_LAT. Full throughput: one read per cycle, back-to-back returns.
- Returns for the previous owner keep routing correctly while the new owner issues.
- Reset mid-operation:
  - all ownership and tags are lost at that edge
  - the caches must re-request
  - in-flight returns arriving during the blank window are dropped with proto_err=0

## Test plan
- I fill, MEM_LAT=4: i_MemRead=1 with i_mem_addr 0x0004..0x000B over 8 cycles after reset; memory returns 1..8. Required response:
  - i_grant high one cycle after the request
  - mem_addr follows the 8 addresses
  - i_MemDataValid high for 8 cycles starting 4 cycles after the first issue, with data 1..8
  - d_MemDataValid stays 0
- Tie: i_MemRead and d_MemRead rise in the same cycle → d_grant first. When d_MemRead drops, i_grant is high the next cycle. A second tie after I finishes → D is granted.
- Write: D owner with d_MemWrite=1, addr 0x0010, data 0xBEEF for 1 cycle → mem_enable=1, mem_wr=1, mem_data_in=0xBEEF. No d_MemDataValid follows. proto_err stays 0.
- Overlap: D issues 2 reads, then drops req; I issues the next cycle. D's words return while I is issuing → only d_MemDataValid pulses for them, followed by I's words on i_MemDataValid.
- Spurious return: mem_data_valid=1 with an empty tag pipe, after the blank window → both valids 0 and proto_err=1, held until rst=0.
- Reset mid-fill: rst=0 for one edge after 3 I reads have issued, with memory still returning those 3 words → grants go to 0, words are dropped, proto_err=0. A new i_MemRead is granted normally.
